// File: rtl/pipe_hazard_unit.sv
// Hazard, forwarding and flush controller for a 5-stage pipeline.
// Tracks in-flight destination registers in a three-entry scoreboard (EX, MEM, WB).
// It generates the following controls:
//   - IF/ID stall and ID/EX bubble.
//   - Per-stage flushes.
//   - Registered EX operand forward selects.
// It also keeps two saturating event counters.
module pipe_hazard_unit #(
  parameter int unsigned REG_ADDR_W   = 5,
  parameter bit          FWD_EN       = 1'b1,
  parameter bit          RF_BYPASS    = 1'b1,
  parameter int unsigned BRANCH_STAGE = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                  i_clk,
  input  logic                  i_arst_n,
  input  logic                  i_enable,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  input  logic                  i_id_use_rs,
  input  logic                  i_id_use_rt,
  input  logic                  i_id_reg_write,
  input  logic                  i_id_mem_read,
  input  logic [REG_ADDR_W-1:0] i_id_waddr,
  input  logic                  i_redir,
  output logic                  o_stall_if_id,
  output logic                  o_bubble_ex,
  output logic                  o_flush_if_id,
  output logic                  o_flush_id_ex,
  output logic                  o_flush_ex_mem,
  output logic [1:0]            o_fwd_a,
  output logic [1:0]            o_fwd_b,
  output logic [CNT_W-1:0]      o_stall_cnt,
  output logic [CNT_W-1:0]      o_flush_cnt
);

  // The EX/MEM register is only flushed when the branch resolves in MEM.
  localparam bit FlushExMem = (BRANCH_STAGE == 3);

  localparam logic [1:0] FwdRf  = 2'd0;
  localparam logic [1:0] FwdMem = 2'd1;  // EX/MEM alu_out
  localparam logic [1:0] FwdWb  = 2'd2;  // MEM/WB wdata

  // One scoreboard slot; wr is set only for a live register-writing instruction.
  typedef struct packed {
    logic                  wr;
    logic                  mem_read;
    logic [REG_ADDR_W-1:0] waddr;
  } sb_entry_t;

  localparam sb_entry_t SbEmpty = '0;

  sb_entry_t r_sb_ex, r_sb_mem, r_sb_wb;
  sb_entry_t w_sb_ex_nxt, w_sb_mem_nxt, w_sb_wb_nxt;

  logic [1:0]       r_fwd_a, r_fwd_b;
  logic [1:0]       w_fwd_a_nxt, w_fwd_b_nxt;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic [CNT_W-1:0] w_stall_cnt_nxt, w_flush_cnt_nxt;

  logic w_ex_hit_a, w_ex_hit_b;
  logic w_mem_hit_a, w_mem_hit_b;
  logic w_wb_hit_a, w_wb_hit_b;
  logic w_load_use, w_fwd_block, w_wb_block, w_hazard;
  logic w_redir, w_stall, w_issue;

  // A used, nonzero source matches a slot holding a live write to the same register.
  function automatic logic f_hit(input logic                  use_src,
                                 input logic [REG_ADDR_W-1:0] src,
                                 input sb_entry_t             ent);
    return use_src && (src != '0) && ent.wr && (ent.waddr == src);
  endfunction

  // The youngest producer wins.
  // The instruction now in EX will be in MEM when the consumer reaches EX.
  function automatic logic [1:0] f_fwd_sel(input logic ex_hit, input logic mem_hit);
    logic [1:0] sel;
    sel = FwdRf;
    if (FWD_EN) begin
      if (ex_hit)       sel = FwdMem;
      else if (mem_hit) sel = FwdWb;
    end
    return sel;
  endfunction

  // Source-versus-scoreboard comparisons for both ID operands.
  always_comb begin
    w_ex_hit_a  = f_hit(i_id_use_rs, i_id_rs, r_sb_ex);
    w_ex_hit_b  = f_hit(i_id_use_rt, i_id_rt, r_sb_ex);
    w_mem_hit_a = f_hit(i_id_use_rs, i_id_rs, r_sb_mem);
    w_mem_hit_b = f_hit(i_id_use_rt, i_id_rt, r_sb_mem);
    w_wb_hit_a  = f_hit(i_id_use_rs, i_id_rs, r_sb_wb);
    w_wb_hit_b  = f_hit(i_id_use_rt, i_id_rt, r_sb_wb);
  end

  // Hazard classification.
  // A redirect outranks a stall, and a disabled unit never stalls or flushes.
  always_comb begin
    w_load_use  = r_sb_ex.mem_read && (w_ex_hit_a || w_ex_hit_b);
    w_fwd_block = !FWD_EN && (w_ex_hit_a || w_ex_hit_b || w_mem_hit_a || w_mem_hit_b);
    w_wb_block  = !RF_BYPASS && (w_wb_hit_a || w_wb_hit_b);
    w_hazard    = i_id_valid && (w_load_use || w_fwd_block || w_wb_block);
    w_redir     = i_enable && i_redir;
    w_stall     = i_enable && w_hazard && !i_redir;
    w_issue     = i_id_valid && !w_stall && !i_redir;
  end

  // Stall and flush outputs are combinational, taking effect in the same cycle.
  always_comb begin
    o_stall_if_id  = w_stall;
    o_bubble_ex    = w_stall;
    o_flush_if_id  = w_redir;
    o_flush_id_ex  = w_redir;
    o_flush_ex_mem = w_redir && FlushExMem;
    o_fwd_a        = r_fwd_a;
    o_fwd_b        = r_fwd_b;
    o_stall_cnt    = r_stall_cnt;
    o_flush_cnt    = r_flush_cnt;
  end

  // Scoreboard shift, forward-select capture and saturating counter next state.
  always_comb begin
    w_sb_wb_nxt  = r_sb_mem;
    w_sb_mem_nxt = (w_redir && FlushExMem) ? SbEmpty : r_sb_ex;
    w_sb_ex_nxt  = SbEmpty;
    if (w_issue) begin
      w_sb_ex_nxt.wr       = i_id_reg_write;
      w_sb_ex_nxt.mem_read = i_id_mem_read;
      w_sb_ex_nxt.waddr    = i_id_waddr;
    end

    // A bubble or a flushed slot in EX never forwards.
    w_fwd_a_nxt = FwdRf;
    w_fwd_b_nxt = FwdRf;
    if (w_issue) begin
      w_fwd_a_nxt = f_fwd_sel(w_ex_hit_a, w_mem_hit_a);
      w_fwd_b_nxt = f_fwd_sel(w_ex_hit_b, w_mem_hit_b);
    end

    w_stall_cnt_nxt = r_stall_cnt;
    if (w_stall && (r_stall_cnt != '1)) begin
      w_stall_cnt_nxt = r_stall_cnt + CNT_W'(1);
    end
    w_flush_cnt_nxt = r_flush_cnt;
    if (w_redir && (r_flush_cnt != '1)) begin
      w_flush_cnt_nxt = r_flush_cnt + CNT_W'(1);
    end
  end

  // State registers.
  // Reset is synchronous; a low enable freezes all state.
  always_ff @(posedge i_clk) begin
    if (!i_arst_n) begin
      r_sb_ex     <= SbEmpty;
      r_sb_mem    <= SbEmpty;
      r_sb_wb     <= SbEmpty;
      r_fwd_a     <= FwdRf;
      r_fwd_b     <= FwdRf;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (i_enable) begin
      r_sb_ex     <= w_sb_ex_nxt;
      r_sb_mem    <= w_sb_mem_nxt;
      r_sb_wb     <= w_sb_wb_nxt;
      r_fwd_a     <= w_fwd_a_nxt;
      r_fwd_b     <= w_fwd_b_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

endmodule
